// File: rtl/sram_requester.sv
// Posted-write / blocking-read requester in front of a toggle-handshake
// SRAM controller: 2-deep write FIFO, one held read, ack-wait timeout.
module sram_requester #(
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] cpu_addr,
   input  logic        cpu_bhe_n,
   input  logic [15:0] cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic        cpu_ready,
   output logic        cpu_rvalid,
   output logic [15:0] cpu_rdata,
   output logic        cmd_err,
   output logic        timeout,
   output logic [23:0] mem_addr,
   output logic        mem_bhe_n,
   output logic [15:0] mem_dout,
   input  logic [15:0] mem_din,
   output logic        req_rd,
   input  logic        ack_rd,
   output logic        req_wr,
   input  logic        ack_wr
);

   localparam logic [7:0] TMO = 8'(TMO_CYCLES);

   typedef enum logic [1:0] {IDLE, WR_WAIT, RD_HOLD, RD_WAIT} state_t;

   state_t      state;
   logic [23:0] f_addr [2];
   logic        f_bhe_n [2];
   logic [15:0] f_data [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic [23:0] rd_addr;
   logic        rd_bhe_n;
   logic        rd_held;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;

   logic push, rd_acc, wr_done, rd_done;
   logic can_issue, issue_wr, issue_rd, waiting;

   assign cpu_ready = !rd_held && (count < 2'd2);
   assign push      = cpu_ready && cpu_wr && !cpu_rd;
   assign rd_acc    = cpu_ready && cpu_rd && !cpu_wr;
   assign wr_done   = (state == WR_WAIT) && (ack_wr == req_wr);
   assign rd_done   = (state == RD_WAIT) && (ack_rd == req_rd);
   assign can_issue = (state == IDLE) || (state == RD_HOLD);
   // Queued writes always drain before any read is issued.
   assign issue_wr  = can_issue && (count != 2'd0);
   assign issue_rd  = can_issue && (count == 2'd0) && (rd_held || rd_acc);
   assign waiting   = ((state == WR_WAIT) && !wr_done) ||
                      ((state == RD_WAIT) && !rd_done);
   assign wait_nxt  = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         rd_addr    <= 24'd0;
         rd_bhe_n   <= 1'b1;
         rd_held    <= 1'b0;
         req_rd     <= 1'b0;
         req_wr     <= 1'b0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= 16'd0;
         cmd_err    <= 1'b0;
         timeout    <= 1'b0;
         mem_addr   <= 24'd0;
         mem_bhe_n  <= 1'b1;
         mem_dout   <= 16'd0;
         wait_cnt   <= 8'd0;
      end else begin
         cpu_rvalid <= 1'b0;
         cmd_err    <= cpu_ready && cpu_rd && cpu_wr;

         if (push) begin
            f_addr[wr_ptr]  <= cpu_addr;
            f_bhe_n[wr_ptr] <= cpu_bhe_n;
            f_data[wr_ptr]  <= cpu_wdata;
            wr_ptr          <= ~wr_ptr;
         end
         if (wr_done) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, wr_done};

         if (rd_acc) begin
            rd_addr  <= cpu_addr;
            rd_bhe_n <= cpu_bhe_n;
            rd_held  <= 1'b1;
         end else if (rd_done) begin
            rd_held  <= 1'b0;
         end

         if (issue_wr || issue_rd) begin
            wait_cnt <= 8'd0;
         end else if (waiting) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == TMO) timeout <= 1'b1;
         end

         unique case (state)
            IDLE, RD_HOLD: begin
               if (issue_wr) begin
                  mem_addr  <= f_addr[rd_ptr];
                  mem_bhe_n <= f_bhe_n[rd_ptr];
                  mem_dout  <= f_data[rd_ptr];
                  req_wr    <= ~req_wr;
                  state     <= WR_WAIT;
               end else if (issue_rd) begin
                  mem_addr  <= rd_held ? rd_addr : cpu_addr;
                  mem_bhe_n <= rd_held ? rd_bhe_n : cpu_bhe_n;
                  req_rd    <= ~req_rd;
                  state     <= RD_WAIT;
               end
            end
            WR_WAIT: begin
               if (wr_done)
                  state <= (rd_held || rd_acc) ? RD_HOLD : IDLE;
            end
            RD_WAIT: begin
               if (rd_done) begin
                  cpu_rdata  <= mem_din;
                  cpu_rvalid <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_requester.sv
// Directed bench for sram_requester; the bench plays the SRAM
// controller by driving ack_rd/ack_wr and mem_din by hand.
module tb_sram_requester;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] cpu_addr;
   logic        cpu_bhe_n;
   logic [15:0] cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic        cpu_ready;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        cmd_err;
   logic        timeout;
   logic [23:0] mem_addr;
   logic        mem_bhe_n;
   logic [15:0] mem_dout;
   logic [15:0] mem_din;
   logic        req_rd;
   logic        ack_rd;
   logic        req_wr;
   logic        ack_wr;

   int vectors = 0;
   int miscompares = 0;

   sram_requester #(.TMO_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_bhe_n  (cpu_bhe_n),
      .cpu_wdata  (cpu_wdata),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_ready  (cpu_ready),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .cmd_err    (cmd_err),
      .timeout    (timeout),
      .mem_addr   (mem_addr),
      .mem_bhe_n  (mem_bhe_n),
      .mem_dout   (mem_dout),
      .mem_din    (mem_din),
      .req_rd     (req_rd),
      .ack_rd     (ack_rd),
      .req_wr     (req_wr),
      .ack_wr     (ack_wr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      cpu_addr  = 24'd0;
      cpu_bhe_n = 1'b1;
      cpu_wdata = 16'd0;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      mem_din   = 16'd0;
      ack_rd    = 1'b0;
      ack_wr    = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", cpu_ready); end
      vectors++; if (req_rd !== 1'b0) begin miscompares++; $display("FAIL rst_req_rd: got %b want 0", req_rd); end
      vectors++; if (req_wr !== 1'b0) begin miscompares++; $display("FAIL rst_req_wr: got %b want 0", req_wr); end
      vectors++; if (mem_bhe_n !== 1'b1) begin miscompares++; $display("FAIL rst_bhe_n: got %b want 1", mem_bhe_n); end
      vectors++; if (mem_addr !== 24'd0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
      vectors++; if (mem_dout !== 16'd0) begin miscompares++; $display("FAIL rst_dout: got %h want 0", mem_dout); end
      vectors++; if (cpu_rdata !== 16'd0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
      vectors++; if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b want 0", timeout); end
      vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
      step();
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after: got %b want 1", cpu_ready); end
      vectors++; if (req_wr !== 1'b0 || req_rd !== 1'b0) begin miscompares++; $display("FAIL rst_idle_req: got rd=%b wr=%b want 0 0", req_rd, req_wr); end
   endtask

   task automatic test_single_write();
      do_reset();
      cpu_wr = 1'b1; cpu_addr = 24'h000100; cpu_wdata = 16'hBEEF; cpu_bhe_n = 1'b0;
      step();
      cpu_wr = 1'b0; cpu_bhe_n = 1'b1; cpu_addr = 24'h0; cpu_wdata = 16'h0;
      vectors++; if (req_wr !== 1'b0) begin miscompares++; $display("FAIL sw_no_early_req: got %b want 0", req_wr); end
      step();
      vectors++; if (req_wr !== 1'b1) begin miscompares++; $display("FAIL sw_req_toggle: got %b want 1", req_wr); end
      vectors++; if (mem_addr !== 24'h000100) begin miscompares++; $display("FAIL sw_addr: got %h want 000100", mem_addr); end
      vectors++; if (mem_dout !== 16'hBEEF) begin miscompares++; $display("FAIL sw_dout: got %h want beef", mem_dout); end
      vectors++; if (mem_bhe_n !== 1'b0) begin miscompares++; $display("FAIL sw_bhe_n: got %b want 0", mem_bhe_n); end
      step(); step(); step();
      vectors++; if (mem_dout !== 16'hBEEF || mem_addr !== 24'h000100) begin miscompares++; $display("FAIL sw_stable: got %h/%h want 000100/beef", mem_addr, mem_dout); end
      ack_wr = 1'b1;
      step();
      step();
      vectors++; if (req_wr !== 1'b1) begin miscompares++; $display("FAIL sw_popped: got req_wr %b want 1", req_wr); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL sw_timeout: got %b want 0", timeout); end
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL sw_ready: got %b want 1", cpu_ready); end
   endtask

   task automatic test_cmd_err();
      do_reset();
      cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 24'h000055; cpu_wdata = 16'h5555;
      step();
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      vectors++; if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL ce_pulse: got %b want 1", cmd_err); end
      vectors++; if (req_rd !== 1'b0 || req_wr !== 1'b0) begin miscompares++; $display("FAIL ce_no_req: got rd=%b wr=%b want 0 0", req_rd, req_wr); end
      step();
      vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL ce_one_cycle: got %b want 0", cmd_err); end
      vectors++; if (req_wr !== 1'b0) begin miscompares++; $display("FAIL ce_fifo_empty: got req_wr %b want 0", req_wr); end
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL ce_ready: got %b want 1", cpu_ready); end
   endtask

   task automatic test_fifo_full();
      do_reset();
      cpu_wr = 1'b1; cpu_addr = 24'h000001; cpu_wdata = 16'h1111; cpu_bhe_n = 1'b0;
      step();
      cpu_addr = 24'h000002; cpu_wdata = 16'h2222;
      step();
      vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL ff_full: got ready %b want 0", cpu_ready); end
      vectors++; if (req_wr !== 1'b1 || mem_dout !== 16'h1111) begin miscompares++; $display("FAIL ff_first_issue: got %b/%h want 1/1111", req_wr, mem_dout); end
      cpu_addr = 24'h000003; cpu_wdata = 16'h3333;
      step();
      vectors++; if (cpu_ready !== 1'b0 || cmd_err !== 1'b0) begin miscompares++; $display("FAIL ff_ignored: got ready %b err %b want 0 0", cpu_ready, cmd_err); end
      ack_wr = 1'b1;
      step();
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL ff_ready_after_ack: got %b want 1", cpu_ready); end
      step();
      cpu_wr = 1'b0;
      vectors++; if (req_wr !== 1'b0 || mem_dout !== 16'h2222 || mem_addr !== 24'h000002) begin miscompares++; $display("FAIL ff_second_issue: got %b/%h/%h want 0/000002/2222", req_wr, mem_addr, mem_dout); end
      vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL ff_third_accepted: got ready %b want 0", cpu_ready); end
      ack_wr = 1'b0;
      step();
      step();
      vectors++; if (req_wr !== 1'b1 || mem_dout !== 16'h3333 || mem_addr !== 24'h000003) begin miscompares++; $display("FAIL ff_third_issue: got %b/%h/%h want 1/000003/3333", req_wr, mem_addr, mem_dout); end
      ack_wr = 1'b1;
      step();
      step();
      vectors++; if (req_wr !== 1'b1 || cpu_ready !== 1'b1) begin miscompares++; $display("FAIL ff_drained: got req_wr %b ready %b want 1 1", req_wr, cpu_ready); end
   endtask

   task automatic test_read_order();
      do_reset();
      cpu_wr = 1'b1; cpu_addr = 24'h000010; cpu_wdata = 16'h1234; cpu_bhe_n = 1'b0;
      step();
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      step();
      cpu_rd = 1'b0; cpu_addr = 24'h0;
      vectors++; if (req_wr !== 1'b1 || req_rd !== 1'b0) begin miscompares++; $display("FAIL ro_write_first: got wr=%b rd=%b want 1 0", req_wr, req_rd); end
      vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL ro_ready_held: got %b want 0", cpu_ready); end
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++; if (req_rd !== 1'b0) begin miscompares++; $display("FAIL ro_no_overtake: cycle %0d got %b want 0", i, req_rd); end
      end
      ack_wr = 1'b1;
      step();
      vectors++; if (req_rd !== 1'b0) begin miscompares++; $display("FAIL ro_not_on_ack_edge: got %b want 0", req_rd); end
      step();
      vectors++; if (req_rd !== 1'b1 || mem_addr !== 24'h000010 || mem_bhe_n !== 1'b0) begin miscompares++; $display("FAIL ro_read_issue: got %b/%h/%b want 1/000010/0", req_rd, mem_addr, mem_bhe_n); end
      mem_din = 16'h1234; ack_rd = 1'b1;
      step();
      mem_din = 16'hDEAD;
      vectors++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin miscompares++; $display("FAIL ro_rdata: got %b/%h want 1/1234", cpu_rvalid, cpu_rdata); end
      step();
      vectors++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h1234) begin miscompares++; $display("FAIL ro_rdata_hold: got %b/%h want 0/1234", cpu_rvalid, cpu_rdata); end
      vectors++; if (cpu_ready !== 1'b1) begin miscompares++; $display("FAIL ro_ready_back: got %b want 1", cpu_ready); end
   endtask

   task automatic test_timeout();
      do_reset();
      cpu_rd = 1'b1; cpu_addr = 24'h000020;
      step();
      cpu_rd = 1'b0;
      vectors++; if (req_rd !== 1'b1 || mem_addr !== 24'h000020) begin miscompares++; $display("FAIL to_issue: got %b/%h want 1/000020", req_rd, mem_addr); end
      step(); step(); step();
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b want 0", timeout); end
      step();
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_set: got %b want 1", timeout); end
      step(); step(); step();
      vectors++; if (timeout !== 1'b1 || cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL to_sticky: got to=%b rv=%b want 1 0", timeout, cpu_rvalid); end
      mem_din = 16'hA5A5; ack_rd = 1'b1;
      step();
      vectors++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hA5A5) begin miscompares++; $display("FAIL to_late_ack: got %b/%h want 1/a5a5", cpu_rvalid, cpu_rdata); end
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_kept: got %b want 1", timeout); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      cpu_rd = 1'b1; cpu_addr = 24'h000030;
      step();
      cpu_rd = 1'b0;
      step();
      vectors++; if (req_rd !== 1'b1) begin miscompares++; $display("FAIL rmr_pending: got %b want 1", req_rd); end
      reset = 1'b1; ack_rd = 1'b0; mem_din = 16'h7777;
      step();
      reset = 1'b0;
      vectors++; if (req_rd !== 1'b0 || cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rmr_cleared: got rd=%b rv=%b want 0 0", req_rd, cpu_rvalid); end
      vectors++; if (cpu_ready !== 1'b1 || timeout !== 1'b0) begin miscompares++; $display("FAIL rmr_ready: got ready=%b to=%b want 1 0", cpu_ready, timeout); end
      step();
      vectors++; if (cpu_rvalid !== 1'b0 || req_rd !== 1'b0 || cpu_rdata !== 16'h0) begin miscompares++; $display("FAIL rmr_no_pulse: got rv=%b rd=%b data=%h want 0 0 0000", cpu_rvalid, req_rd, cpu_rdata); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_write();
      test_cmd_err();
      test_fifo_full();
      test_read_order();
      test_timeout();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_requester.md
SRAM_REQUESTER -- requirements
Module: sram_requester

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 255, meaning the ack-wait cycle count that sets the timeout flag (1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_addr in 24, cpu_bhe_n in 1, cpu_wdata in 16: command address, high-byte enable (active low), write data.
REQ-005 SHALL have ports cpu_rd in 1, cpu_wr in 1: single-cycle command strobes.
REQ-006 SHALL have ports cpu_ready out 1 (command accepted this cycle if strobed), cpu_rvalid out 1 (read-data pulse), cpu_rdata out 16 (read data).
REQ-007 SHALL have ports cmd_err out 1 (one-cycle pulse) and timeout out 1 (sticky flag).
REQ-008 SHALL have ports mem_addr out 24, mem_bhe_n out 1, mem_dout out 16: request fields toward the SRAM controller.
REQ-009 SHALL have ports mem_din in 16: read data from the controller.
REQ-010 SHALL have ports req_rd out 1, ack_rd in 1, req_wr out 1, ack_wr in 1: toggle handshake; a request is pending while req_x != ack_x.

Function
REQ-011 SHALL hold a 2-entry posted-write FIFO, each entry {addr[23:0], bhe_n, data[15:0]}.
REQ-012 SHALL drive cpu_ready = (FSM not holding a read) and (FIFO count < 2).
REQ-013 SHALL accept cpu_wr when cpu_ready=1 and push the entry at that edge.
REQ-014 SHALL accept cpu_rd when cpu_ready=1 and latch addr/bhe_n into a read register at that edge.
REQ-015 SHALL, when cpu_rd and cpu_wr are both high, accept neither and pulse cmd_err for one cycle.
REQ-016 SHALL ignore strobes while cpu_ready=0, with no error.
REQ-017 SHALL implement FSM states IDLE, WR_WAIT, RD_HOLD, RD_WAIT.
REQ-018 IDLE with FIFO non-empty: SHALL drive mem_addr/mem_bhe_n/mem_dout from the FIFO head, toggle req_wr, and go to WR_WAIT at the same edge; this takes priority over a held read.
REQ-019 IDLE with FIFO empty and a read held: SHALL drive mem_addr/mem_bhe_n from the read register, toggle req_rd, and go to RD_WAIT.
REQ-020 Accepting a read SHALL move the FSM to RD_HOLD when the FIFO is non-empty or a write is pending, else issue directly as in REQ-019.
REQ-021 Reads SHALL never overtake queued writes; RD_HOLD SHALL wait until the FIFO is empty and the FSM is idle.
REQ-022 WR_WAIT: when ack_wr == req_wr, SHALL pop the head and return to IDLE (or RD_HOLD if a read is held); the next issue occurs no earlier than the following edge.
REQ-023 RD_WAIT: when ack_rd == req_rd, SHALL register mem_din into cpu_rdata, pulse cpu_rvalid for exactly one cycle, and return to IDLE.
REQ-024 mem_addr, mem_bhe_n and mem_dout SHALL remain stable from the req toggle until the matching ack.
REQ-025 SHALL allow at most one outstanding request (read or write) at any time.
REQ-026 A push and a pop on the same edge SHALL leave the count unchanged and preserve order; FIFO pointers SHALL wrap modulo 2.
REQ-027 SHALL run an 8-bit wait counter that clears on each issue and increments in WR_WAIT/RD_WAIT; when it reaches TMO_CYCLES it SHALL set timeout, which stays set until reset while the transaction keeps waiting.
REQ-028 cpu_rdata SHALL hold its last value until the next read completes.

Reset
REQ-029 On reset SHALL set state=IDLE, FIFO empty, read register cleared, req_rd=req_wr=0, cpu_rvalid=0, cmd_err=0, timeout=0, cpu_rdata=0, mem_addr=0, mem_dout=0, mem_bhe_n=1, and wait counter=0.
REQ-030 Reset mid-transaction SHALL abandon the pending request and discard queued writes; the controller SHALL be reset in the same cycle so that its ack toggles return to 0.
REQ-031 cpu_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Single write: cpu_wr with addr 0x000100, data 0xBEEF, bhe_n 0 -> req_wr toggles 1 cycle later with mem_addr=0x000100 and mem_dout=0xBEEF; an ack after 3 cycles pops the FIFO.
REQ-033 FIFO full: three back-to-back writes with ack stalled -> cpu_ready=0 after the second; the third is ignored until the first ack, then accepted.
REQ-034 Read ordering: write 0x1234 to 0x000010, then read 0x000010 while the write ack is delayed 5 cycles -> req_rd toggles only after ack_wr matches; ack_rd with mem_din=0x1234 -> cpu_rvalid pulse, cpu_rdata=0x1234.
REQ-035 Simultaneous strobes: cpu_rd=cpu_wr=1 -> cmd_err one-cycle pulse, no req toggle, FIFO count stays 0.
REQ-036 Timeout: issue a read and never ack with TMO_CYCLES=4 -> timeout=1 after 4 wait cycles, stays set; a later ack completes the read normally.
REQ-037 Reset mid-read: assert reset in RD_WAIT -> req_rd=0, cpu_ready=1, no cpu_rvalid pulse.
